score_keeper: RTL and testbench
===============================

// Module: score_keeper
// PURPOSE
//  Downstream of the ball mover: watches ball_x for goal events, keeps both players' scores and sequences the match.
//  Drives play_en into the ball mover's active-low reset input: 0 = ball held at centre, 1 = ball runs.
//  Also holds play_en low for a serve pause after each point and ends the game at WIN_SCORE.
//  Scores feed the pixel renderer / score display.
// PARAMETERS
//  H_ACTIVE      640         right goal position; ball_x >= H_ACTIVE is a right-edge goal
//  WIN_SCORE     7           points needed to win; legal range 1..15
//  SERVE_CYCLES  25_000_000  clk cycles play_en stays low after a point; must be >= 1
//  CNT_W         25          serve counter width; must satisfy 2**CNT_W > SERVE_CYCLES
// PORTS
//  clk          in   1   system clock, the only clock
//  reset        in   1   synchronous, active-high reset
//  ball_x       in   10  ball x position from the ball mover
//  start        in   1   level or pulse; acted on only in IDLE and GAME_OVER
//  play_en      out  1   1 only in PLAY; drives the ball mover's run/reset-n input
//  p1_score     out  4   left player score
//  p2_score     out  4   right player score
//  point_pulse  out  1   one-cycle strobe the cycle after a goal is accepted
//  game_over    out  1   1 while in GAME_OVER
//  winner       out  2   00 none, 01 P1, 10 P2; held until the next game starts
// BEHAVIOUR
//  Reset: state=IDLE; play_en=0; scores=0; point_pulse=0; game_over=0; winner=00; serve_cnt=0; edge flags=0.
//  Reset takes priority over everything, mid-game included.
//  Goal detect (registered edge detect):
//   - at_l = (ball_x==0); at_r = (ball_x>=H_ACTIVE).
//   - goal_l = at_l & ~at_l_q; goal_r = at_r & ~at_r_q.
//   - at_l_q and at_r_q update every cycle in every state, so a ball parked at an edge never re-fires.
//  Scoring:
//   - goal_l is a point for P2; goal_r is a point for P1.
//   - Goals are acted on only in PLAY; they are ignored in every other state.
//   - Simultaneous goal_l & goal_r: neither score changes, point_pulse still fires, FSM still goes to POINT.
//   - Scores never exceed WIN_SCORE; no wrap.
//  FSM:
//   - IDLE: play_en=0. start -> PLAY.
//   - PLAY: play_en=1. Accepted goal at cycle N: score visible and point_pulse=1 at N+1, state at N+1 is:
//       - GAME_OVER if the new score == WIN_SCORE; winner set in the same cycle;
//       - otherwise POINT, with serve_cnt cleared to 0.
//   - POINT: play_en=0. serve_cnt increments each cycle; at serve_cnt==SERVE_CYCLES-1 -> PLAY next cycle.
//       - start is ignored in POINT.
//   - GAME_OVER: play_en=0; game_over=1; scores and winner frozen.
//       - start -> PLAY next cycle with both scores=0 and winner=00.
//  Latency: ball_x hits an edge at cycle N -> play_en falls at N+1.
//  All outputs are registered.
// CONFIGURATION
//  SCORE_BCD_EN defined:
//   - adds ports p1_bcd and p2_bcd, out, 8 bits each, {tens,units} BCD of each score;
//   - each BCD output is registered one cycle after its score; reset value 8'h00.
//  SCORE_BCD_EN undefined: the BCD ports and logic are absent; all other behaviour is identical.
// STRUCTURE
//  Package pong_pkg:
//   - H_ACTIVE and V_ACTIVE constants;
//   - state typedef {IDLE, PLAY, POINT, GAME_OVER};
//   - winner encoding constants.
//  Sub-module serve_timer:
//   - inputs clear and run; output done;
//   - parameters SERVE_CYCLES and CNT_W;
//   - instantiated once for the POINT pause.
// TESTING
//  1 Reset, then start=1 for 1 cycle -> play_en=1 the next cycle; scores 0/0.
//  2 SERVE_CYCLES=4; ball_x=0 for 3 cycles in PLAY:
//     - p2_score=1 and point_pulse=1 for exactly 1 cycle;
//     - play_en low 4 cycles, then back to 1;
//     - no double count while ball_x stays at 0.
//  3 ball_x=640 -> p1_score increments; ball_x=700 held -> counts once only.
//  4 WIN_SCORE=3; three P1 goals -> game_over=1, winner=01, play_en=0;
//     - further goals leave scores 3/0;
//     - start -> scores 0/0, winner=00, play_en=1.
//  5 Goal during POINT or IDLE -> no score change; reset asserted mid-POINT -> IDLE and all outputs at reset values.
//  6 SCORE_BCD_EN defined, WIN_SCORE=12, P2 reaches 11 -> p2_bcd=8'h11 one cycle after p2_score=11.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared constants and types for the pong match logic: screen geometry,
// match state encoding, winner codes and a small score-to-BCD helper.
package pong_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned V_ACTIVE = 480;

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    POINT,
    GAME_OVER
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

  // Scores are at most 15, so the tens digit is only ever 0 or 1.
  function automatic logic [7:0] to_bcd(input logic [3:0] v);
    if (v >= 4'd10) begin
      return {4'd1, v - 4'd10};
    end
    return {4'd0, v};
  endfunction

endpackage

// File: rtl/serve_timer.sv
// Serve pause timer: counts while run is high and flags the final cycle
// of a SERVE_CYCLES-long pause; clear restarts the count from zero.
module serve_timer #(
  parameter int unsigned SERVE_CYCLES = 25_000_000,
  parameter int unsigned CNT_W        = 25
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic done
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(SERVE_CYCLES - 1);

  logic [CNT_W-1:0] serve_cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      serve_cnt <= '0;
    end else if (run) begin
      serve_cnt <= (serve_cnt == LAST) ? '0 : serve_cnt + CNT_W'(1);
    end
  end

  assign done = run && (serve_cnt == LAST);

endmodule

// File: rtl/score_keeper.sv
// Match sequencer: detects goals from ball_x, keeps scores, gates the ball
// mover via play_en. Define SCORE_BCD_EN to add registered BCD score ports.
module score_keeper #(
  parameter int unsigned H_ACTIVE     = pong_pkg::H_ACTIVE,
  parameter int unsigned WIN_SCORE    = 7,
  parameter int unsigned SERVE_CYCLES = 25_000_000,
  parameter int unsigned CNT_W        = 25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] ball_x,
  input  logic       start,
  output logic       play_en,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic       point_pulse,
  output logic       game_over,
  output logic [1:0] winner
`ifdef SCORE_BCD_EN
  ,
  output logic [7:0] p1_bcd,
  output logic [7:0] p2_bcd
`endif
);

  import pong_pkg::*;

  localparam logic [3:0] WIN = 4'(WIN_SCORE);

  state_t state;
  logic   at_l, at_r;
  logic   at_l_q, at_r_q;
  logic   goal_l, goal_r;
  logic   serve_done;

  assign at_l   = (ball_x == 10'd0);
  assign at_r   = (32'(ball_x) >= H_ACTIVE);
  assign goal_l = at_l & ~at_l_q;
  assign goal_r = at_r & ~at_r_q;

  serve_timer #(
    .SERVE_CYCLES(SERVE_CYCLES),
    .CNT_W       (CNT_W)
  ) u_serve_timer (
    .clk  (clk),
    .reset(reset),
    .clear(state != POINT),
    .run  (state == POINT),
    .done (serve_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      play_en     <= 1'b0;
      p1_score    <= '0;
      p2_score    <= '0;
      point_pulse <= 1'b0;
      game_over   <= 1'b0;
      winner      <= WIN_NONE;
      at_l_q      <= 1'b0;
      at_r_q      <= 1'b0;
    end else begin
      at_l_q      <= at_l;
      at_r_q      <= at_r;
      point_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= PLAY;
            play_en <= 1'b1;
          end
        end
        PLAY: begin
          // A simultaneous two-edge goal still pauses play but scores nobody.
          if (goal_l || goal_r) begin
            point_pulse <= 1'b1;
            state       <= POINT;
            play_en     <= 1'b0;
            if (goal_r && !goal_l && p1_score < WIN) begin
              p1_score <= p1_score + 4'd1;
              if (p1_score + 4'd1 == WIN) begin
                state     <= GAME_OVER;
                game_over <= 1'b1;
                winner    <= WIN_P1;
              end
            end else if (goal_l && !goal_r && p2_score < WIN) begin
              p2_score <= p2_score + 4'd1;
              if (p2_score + 4'd1 == WIN) begin
                state     <= GAME_OVER;
                game_over <= 1'b1;
                winner    <= WIN_P2;
              end
            end
          end
        end
        POINT: begin
          if (serve_done) begin
            state   <= PLAY;
            play_en <= 1'b1;
          end
        end
        GAME_OVER: begin
          if (start) begin
            state     <= PLAY;
            play_en   <= 1'b1;
            game_over <= 1'b0;
            p1_score  <= '0;
            p2_score  <= '0;
            winner    <= WIN_NONE;
          end
        end
        default: begin
          state   <= IDLE;
          play_en <= 1'b0;
        end
      endcase
    end
  end

`ifdef SCORE_BCD_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      p1_bcd <= 8'h00;
      p2_bcd <= 8'h00;
    end else begin
      p1_bcd <= to_bcd(p1_score);
      p2_bcd <= to_bcd(p2_score);
    end
  end
`endif

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper: directed match scenarios followed by
// randomized ball positions, compared every cycle against a behavioural model.
module tb_score_keeper;

`ifdef SCORE_BCD_EN
  localparam int unsigned WIN = 12;
`else
  localparam int unsigned WIN = 3;
`endif
  localparam int unsigned SERVE = 4;

  localparam int PH_IDLE  = 0;
  localparam int PH_PLAY  = 1;
  localparam int PH_PAUSE = 2;
  localparam int PH_OVER  = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] ball_x = 10'd320;
  logic       start = 1'b0;
  logic       play_en;
  logic [3:0] p1_score, p2_score;
  logic       point_pulse, game_over;
  logic [1:0] winner;
`ifdef SCORE_BCD_EN
  logic [7:0] p1_bcd, p2_bcd;
`endif

  score_keeper #(
    .H_ACTIVE    (640),
    .WIN_SCORE   (WIN),
    .SERVE_CYCLES(SERVE),
    .CNT_W       (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ball_x     (ball_x),
    .start      (start),
    .play_en    (play_en),
    .p1_score   (p1_score),
    .p2_score   (p2_score),
    .point_pulse(point_pulse),
    .game_over  (game_over),
    .winner     (winner)
`ifdef SCORE_BCD_EN
    ,
    .p1_bcd     (p1_bcd),
    .p2_bcd     (p2_bcd)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  int m_phase, m_p1, m_p2, m_win, m_left, m_pulse, m_bcd1, m_bcd2;
  bit m_prev_l, m_prev_r;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got=%0d expected=%0d", tag, $time, got, exp);
    end
  endtask

  function automatic int bcd(input int s);
    return (s / 10) * 16 + (s % 10);
  endfunction

  // Advances the match model by one clock given the inputs for that clock.
  task automatic model_update(input int bx, input bit st, input bit rst);
    bit gl, gr;
    if (rst) begin
      m_phase = PH_IDLE; m_p1 = 0; m_p2 = 0; m_win = 0; m_pulse = 0;
      m_left = 0; m_prev_l = 0; m_prev_r = 0; m_bcd1 = 0; m_bcd2 = 0;
      return;
    end
    m_bcd1 = bcd(m_p1);
    m_bcd2 = bcd(m_p2);
    gl = (bx == 0) && !m_prev_l;
    gr = (bx >= 640) && !m_prev_r;
    m_prev_l = (bx == 0);
    m_prev_r = (bx >= 640);
    m_pulse = 0;
    case (m_phase)
      PH_IDLE: if (st) m_phase = PH_PLAY;
      PH_PLAY: begin
        if (gl || gr) begin
          m_pulse = 1;
          m_phase = PH_PAUSE;
          m_left  = SERVE;
          if (gr && !gl) m_p1++;
          if (gl && !gr) m_p2++;
          if (m_p1 == WIN) begin m_phase = PH_OVER; m_win = 1; end
          if (m_p2 == WIN) begin m_phase = PH_OVER; m_win = 2; end
        end
      end
      PH_PAUSE: begin
        m_left--;
        if (m_left == 0) m_phase = PH_PLAY;
      end
      default: begin
        if (st) begin
          m_phase = PH_PLAY; m_p1 = 0; m_p2 = 0; m_win = 0;
        end
      end
    endcase
  endtask

  task automatic step(input int bx, input bit st, input bit rst);
    ball_x = 10'(bx);
    start  = st;
    reset  = rst;
    model_update(bx, st, rst);
    @(posedge clk);
    #1;
    check("play_en",     int'(play_en),     int'(m_phase == PH_PLAY));
    check("game_over",   int'(game_over),   int'(m_phase == PH_OVER));
    check("p1_score",    int'(p1_score),    m_p1);
    check("p2_score",    int'(p2_score),    m_p2);
    check("point_pulse", int'(point_pulse), m_pulse);
    check("winner",      int'(winner),      m_win);
`ifdef SCORE_BCD_EN
    check("p1_bcd",      int'(p1_bcd),      m_bcd1);
    check("p2_bcd",      int'(p2_bcd),      m_bcd2);
`endif
  endtask

  initial begin
    int hold, val, r;
    // Reset and idle, including a ball parked at the left goal while idle
    repeat (2) step(320, 0, 1);
    step(0, 0, 0);
    repeat (2) step(320, 0, 0);
    step(320, 1, 0);
    repeat (3) step(320, 0, 0);
    // Left goal held for three cycles, then full serve pause
    repeat (3) step(0, 0, 0);
    repeat (8) step(320, 0, 0);
    // Right goal at the exact edge, then held beyond it
    step(640, 0, 0);
    repeat (10) step(700, 0, 0);
    repeat (8) step(320, 0, 0);
    // Goal attempt during the serve pause
    step(640, 0, 0);
    step(320, 0, 0);
    step(0, 0, 0);
    repeat (8) step(320, 0, 0);
    // Drive toward a win, then goals while the game is over, then restart
    repeat (WIN) begin
      step(1023, 0, 0);
      repeat (6) step(320, 0, 0);
    end
    step(0, 0, 0);
    step(320, 0, 0);
    step(640, 0, 0);
    step(320, 1, 0);
    repeat (3) step(320, 0, 0);
    // Reset in the middle of a serve pause
    step(0, 0, 0);
    step(320, 0, 0);
    step(320, 0, 1);
    repeat (3) step(320, 0, 0);
    // Long run of P2 goals (crosses 10 when the win score allows)
    step(320, 1, 0);
    repeat (11) begin
      step(0, 0, 0);
      repeat (6) step(320, 0, 0);
    end
    step(320, 1, 0);
    // Simultaneous edge flags cannot both rise from one ball_x, so mix randomly
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 9);
      if (r < 2)       val = 0;
      else if (r == 2) val = 640;
      else if (r == 3) val = $urandom_range(641, 1023);
      else             val = $urandom_range(1, 639);
      hold = $urandom_range(1, 8);
      for (int k = 0; k < hold; k++) begin
        step(val, ($urandom_range(0, 7) == 0), ($urandom_range(0, 299) == 0));
      end
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
